// File: rtl/rr_mux41_sel_ctrl_if.sv
// rtl/rr_mux41_sel_ctrl_if.sv - request/select bundle between requesters and the 4:1 mux select controller
//
// Signals:
//   REQ  [3:0] channel requests, bit i asks for mux data input Di
//   DONE       consumer has taken the current mux output
//   SD1        mux select LSB ({SD2,SD1} = granted index)
//   SD2        mux select MSB
//   GNT  [3:0] one-hot grant, zero when idle
//   VLD        mux output is settled and belongs to the granted channel
//   TOUT       one-cycle pulse on a hold-timeout release
// Modports:
//   master - requester/consumer side (drives REQ/DONE)
//   slave  - select controller side (drives selects, grant and flags)

interface rr_mux41_sel_ctrl_if;
    logic [3:0] REQ;
    logic       DONE;
    logic       SD1;
    logic       SD2;
    logic [3:0] GNT;
    logic       VLD;
    logic       TOUT;

    modport master (
        output REQ,
        output DONE,
        input  SD1,
        input  SD2,
        input  GNT,
        input  VLD,
        input  TOUT
    );

    modport slave (
        input  REQ,
        input  DONE,
        output SD1,
        output SD2,
        output GNT,
        output VLD,
        output TOUT
    );
endinterface

// File: rtl/rr_mux41_sel_ctrl.sv
// rtl/rr_mux41_sel_ctrl.sv - round-robin select controller for a 4:1 mux cell
//
// Parameters:
//   SETTLE  (1..15)  cycles VLD stays low after every select change
//   MAXHOLD (0..255) max BUSY cycles per grant before forced release, 0 = no limit
// Ports:
//   CK   clock, rising edge
//   CDN  asynchronous active-low reset
//   bus  slave side of rr_mux41_sel_ctrl_if (REQ/DONE in; SD1/SD2/GNT/VLD/TOUT out)
// All outputs come straight from flops.

module rr_mux41_sel_ctrl #(
    parameter int unsigned SETTLE  = 1,
    parameter int unsigned MAXHOLD = 0
) (
    input  logic               CK,
    input  logic               CDN,
    rr_mux41_sel_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_BUSY   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(MAXHOLD - 1);
    localparam bit         HOLD_EN     = (MAXHOLD != 0);

    state_t     state_q,  state_d;
    logic [1:0] sel_q,    sel_d;
    logic [1:0] last_q,   last_d;
    logic [3:0] gnt_q,    gnt_d;
    logic       vld_q,    vld_d;
    logic       tout_q,   tout_d;
    logic [3:0] settle_q, settle_d;
    logic [7:0] hold_q,   hold_d;

    logic [3:0] req_clean;
    logic       done_known;
    logic       rel;
    logic       arb_en;
    logic [3:0] arb_req;
    logic [1:0] arb_start;
    logic [2:0] pick;

    // First set bit of req searching upward from start with wrap 3 -> 0.
    // Returns {found, index}. Scanning offsets high-to-low lets the
    // lowest offset overwrite, so it wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Unknown request bits never win arbitration.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_clean[i] = (bus.REQ[i] === 1'b1);
        end
        done_known = (bus.DONE === 1'b0) || (bus.DONE === 1'b1);
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        vld_d     = vld_q;
        tout_d    = 1'b0;
        settle_d  = settle_q;
        hold_d    = hold_q;
        rel       = 1'b0;
        arb_en    = 1'b0;
        arb_req   = req_clean;
        arb_start = last_q + 2'd1;
        pick      = 3'b000;

        case (state_q)
            ST_IDLE: begin
                arb_en = 1'b1;
            end
            ST_SETTLE: begin
                vld_d = 1'b0;
                if (!req_clean[sel_q]) begin
                    rel = 1'b1;
                end else if (settle_q == 4'd0) begin
                    state_d = ST_BUSY;
                    vld_d   = 1'b1;
                    hold_d  = 8'd0;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            ST_BUSY: begin
                vld_d = 1'b1;
                if (!done_known) begin
                    // Unknown consumer handshake: freeze and make it visible on VLD.
                    vld_d = 1'bx;
                end else if (bus.DONE) begin
                    rel = 1'b1;
                end else if (!req_clean[sel_q]) begin
                    rel = 1'b1;
                end else if (HOLD_EN && (hold_q == HOLD_LAST)) begin
                    rel    = 1'b1;
                    tout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'd0;
                vld_d   = 1'b0;
            end
        endcase

        // A release re-arbitrates on the same edge among the other channels,
        // starting just after the channel being released.
        if (rel) begin
            vld_d     = 1'b0;
            arb_en    = 1'b1;
            arb_req   = req_clean & ~(4'b0001 << sel_q);
            arb_start = sel_q + 2'd1;
        end

        if (arb_en) begin
            pick = rr_pick(arb_req, arb_start);
            if (pick[2]) begin
                sel_d    = pick[1:0];
                last_d   = pick[1:0];
                gnt_d    = 4'b0001 << pick[1:0];
                settle_d = SETTLE_LOAD;
                vld_d    = 1'b0;
                state_d  = ST_SETTLE;
            end else if (rel) begin
                gnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge CK or negedge CDN) begin
        if (!CDN) begin
            state_q  <= ST_IDLE;
            sel_q    <= 2'd0;
            last_q   <= 2'd3;
            gnt_q    <= 4'd0;
            vld_q    <= 1'b0;
            tout_q   <= 1'b0;
            settle_q <= 4'd0;
            hold_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            vld_q    <= vld_d;
            tout_q   <= tout_d;
            settle_q <= settle_d;
            hold_q   <= hold_d;
        end
    end

    assign bus.SD1  = sel_q[0];
    assign bus.SD2  = sel_q[1];
    assign bus.GNT  = gnt_q;
    assign bus.VLD  = vld_q;
    assign bus.TOUT = tout_q;

endmodule

// File: tb/tb_rr_mux41_sel_ctrl.sv
// tb/tb_rr_mux41_sel_ctrl.sv - scoreboard bench for rr_mux41_sel_ctrl

module tb_rr_mux41_sel_ctrl;

    logic CK  = 1'b0;
    logic CDN = 1'b0;

    always #5 CK = ~CK;

    rr_mux41_sel_ctrl_if if0 ();
    rr_mux41_sel_ctrl_if if1 ();
    rr_mux41_sel_ctrl_if if2 ();
    rr_mux41_sel_ctrl_if if3 ();

    rr_mux41_sel_ctrl #(.SETTLE(1), .MAXHOLD(0)) u_s1   (.CK(CK), .CDN(CDN), .bus(if0));
    rr_mux41_sel_ctrl #(.SETTLE(3), .MAXHOLD(0)) u_s3   (.CK(CK), .CDN(CDN), .bus(if1));
    rr_mux41_sel_ctrl #(.SETTLE(1), .MAXHOLD(4)) u_mh4  (.CK(CK), .CDN(CDN), .bus(if2));
    rr_mux41_sel_ctrl #(.SETTLE(1), .MAXHOLD(2)) u_mh2  (.CK(CK), .CDN(CDN), .bus(if3));

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q [$];
    int         dut_q [$];
    string      tag_q [$];

    // Observed word: {GNT[3:0], SD2, SD1, VLD, TOUT}
    function automatic logic [8:0] obs(input int d);
        case (d)
            0:       return {if0.GNT, if0.SD2, if0.SD1, if0.VLD, if0.TOUT};
            1:       return {if1.GNT, if1.SD2, if1.SD1, if1.VLD, if1.TOUT};
            2:       return {if2.GNT, if2.SD2, if2.SD1, if2.VLD, if2.TOUT};
            default: return {if3.GNT, if3.SD2, if3.SD1, if3.VLD, if3.TOUT};
        endcase
    endfunction

    function automatic logic [8:0] expw(input logic [3:0] g, input logic [1:0] s,
                                        input logic v, input logic t);
        return {g, s[1], s[0], v, t};
    endfunction

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic [3:0] req, input logic done);
        case (d)
            0:       begin if0.REQ = req; if0.DONE = done; end
            1:       begin if1.REQ = req; if1.DONE = done; end
            2:       begin if2.REQ = req; if2.DONE = done; end
            default: begin if3.REQ = req; if3.DONE = done; end
        endcase
    endtask

    // One clock of stimulus: inputs applied at the falling edge, expected
    // outputs after the following rising edge queued for the monitor.
    task automatic cyc(input int d, input logic [3:0] req, input logic done,
                       input logic [3:0] eg, input logic [1:0] es,
                       input logic ev, input logic et, input string tag);
        @(negedge CK);
        CDN = 1'b1;
        drive(d, req, done);
        exp_q.push_back(expw(eg, es, ev, et));
        dut_q.push_back(d);
        tag_q.push_back(tag);
    endtask

    always @(posedge CK) begin
        #1;
        if (exp_q.size() != 0) begin
            check(tag_q.pop_front(), obs(dut_q.pop_front()), exp_q.pop_front());
        end
    end

    task automatic do_reset();
        @(negedge CK);
        CDN = 1'b0;
        for (int i = 0; i < 4; i++) drive(i, 4'b0000, 1'b0);
        repeat (2) @(negedge CK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) drive(i, 4'b0000, 1'b0);
        repeat (3) @(negedge CK);
        for (int i = 0; i < 4; i++) check($sformatf("reset_dut%0d", i), obs(i), 9'd0);

        // SETTLE=1 single request, DONE release to idle with selects retained
        cyc(0, 4'b0100, 1'b0, 4'b0100, 2'b10, 1'b0, 1'b0, "t1_grant");
        cyc(0, 4'b0100, 1'b0, 4'b0100, 2'b10, 1'b1, 1'b0, "t1_vld");
        cyc(0, 4'b0100, 1'b1, 4'b0000, 2'b10, 1'b0, 1'b0, "t1_done");
        cyc(0, 4'b0000, 1'b0, 4'b0000, 2'b10, 1'b0, 1'b0, "t1_idle");

        // Full rotation with back-to-back grants; DONE in SETTLE is ignored
        do_reset();
        cyc(0, 4'b1111, 1'b0, 4'b0001, 2'b00, 1'b0, 1'b0, "t2_g0");
        cyc(0, 4'b1111, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0, "t2_b0");
        cyc(0, 4'b1111, 1'b1, 4'b0010, 2'b01, 1'b0, 1'b0, "t2_g1");
        cyc(0, 4'b1111, 1'b1, 4'b0010, 2'b01, 1'b1, 1'b0, "t2_b1_done_in_settle");
        cyc(0, 4'b1111, 1'b1, 4'b0100, 2'b10, 1'b0, 1'b0, "t2_g2");
        cyc(0, 4'b1111, 1'b0, 4'b0100, 2'b10, 1'b1, 1'b0, "t2_b2");
        cyc(0, 4'b1111, 1'b1, 4'b1000, 2'b11, 1'b0, 1'b0, "t2_g3");
        cyc(0, 4'b1111, 1'b0, 4'b1000, 2'b11, 1'b1, 1'b0, "t2_b3");
        cyc(0, 4'b1111, 1'b1, 4'b0001, 2'b00, 1'b0, 1'b0, "t2_wrap_g0");
        cyc(0, 4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, "t2_drop_idle");

        // SETTLE=3: three low-VLD cycles, then a drop inside the settle window
        cyc(1, 4'b0001, 1'b0, 4'b0001, 2'b00, 1'b0, 1'b0, "t3_grant");
        cyc(1, 4'b0001, 1'b0, 4'b0001, 2'b00, 1'b0, 1'b0, "t3_settle2");
        cyc(1, 4'b0001, 1'b0, 4'b0001, 2'b00, 1'b0, 1'b0, "t3_settle3");
        cyc(1, 4'b0001, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0, "t3_vld");
        cyc(1, 4'b0001, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0, "t3_done");
        cyc(1, 4'b0001, 1'b0, 4'b0001, 2'b00, 1'b0, 1'b0, "t3_regrant");
        cyc(1, 4'b0001, 1'b0, 4'b0001, 2'b00, 1'b0, 1'b0, "t3_settle_a");
        cyc(1, 4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, "t3_drop");
        cyc(1, 4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, "t3_no_vld");

        // MAXHOLD=4: four BUSY cycles then timeout hands over to channel 1
        cyc(2, 4'b0011, 1'b0, 4'b0001, 2'b00, 1'b0, 1'b0, "t4_grant");
        for (int i = 0; i < 4; i++)
            cyc(2, 4'b0011, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0, $sformatf("t4_busy%0d", i));
        cyc(2, 4'b0011, 1'b0, 4'b0010, 2'b01, 1'b0, 1'b1, "t4_tout");
        cyc(2, 4'b0011, 1'b0, 4'b0010, 2'b01, 1'b1, 1'b0, "t4_tout_clear");
        cyc(2, 4'b0000, 1'b0, 4'b0000, 2'b01, 1'b0, 1'b0, "t4_drop");

        // MAXHOLD=2: DONE coincides with timeout, TOUT must stay low
        cyc(3, 4'b0001, 1'b0, 4'b0001, 2'b00, 1'b0, 1'b0, "t5_grant");
        cyc(3, 4'b0001, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0, "t5_busy0");
        cyc(3, 4'b0001, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0, "t5_busy1");
        cyc(3, 4'b0001, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0, "t5_done_tout");

        // Asynchronous reset while BUSY on channel 2
        cyc(0, 4'b0100, 1'b0, 4'b0100, 2'b10, 1'b0, 1'b0, "t6_grant2");
        cyc(0, 4'b0100, 1'b0, 4'b0100, 2'b10, 1'b1, 1'b0, "t6_busy2");
        @(negedge CK);
        #1;
        CDN = 1'b0;
        drive(0, 4'b0101, 1'b0);
        #1;
        check("t6_async_reset", obs(0), 9'd0);
        @(negedge CK);
        cyc(0, 4'b0101, 1'b0, 4'b0001, 2'b00, 1'b0, 1'b0, "t6_ptr_ch0");
        cyc(0, 4'b0101, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0, "t6_busy0");
        cyc(0, 4'b0101, 1'b1, 4'b0100, 2'b10, 1'b0, 1'b0, "t6_next_ch2");
        cyc(0, 4'b0000, 1'b0, 4'b0000, 2'b10, 1'b0, 1'b0, "t6_idle");

        @(negedge CK);
        check("sb_drain", 9'(exp_q.size()), 9'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
